// File: rtl/stack_pkg.sv
// Shared types and helpers for the parametrised LIFO stack.
// Imported by the stack core and its storage array.
package stack_pkg;

  typedef enum logic [1:0] {
    OP_IDLE    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } op_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic op_e decode_op(
    input logic push,
    input logic pop
  );
    op_e op;
    unique case (1'b1)
      (push && pop):  op = OP_REPLACE;
      (push && !pop): op = OP_PUSH;
      (!push && pop): op = OP_POP;
      default:        op = OP_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the core's count defines validity.
module stack_mem
  import stack_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_lifo_core.sv
// LIFO stack core: op decode, occupancy count, sticky errors
// and the registered pop-data handshake around stack_mem.
module stack_lifo_core
  import stack_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter int  DEPTH  = 16,
  localparam int CNT_W  = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  input  logic              clr_err,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [DATA_W-1:0] top,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dv_q, dv_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              is_empty;
  logic              is_full;
  logic [AW-1:0]     raddr;
  logic [AW-1:0]     waddr;
  logic              we;
  logic [DATA_W-1:0] rdata;
  op_e               op;

  assign op       = decode_op(push, pop);
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(DEPTH));
  assign raddr    = AW'(count_q - CNT_W'(1));

  stack_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (din),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Clear is applied first so a same-cycle error wins.
  always_comb begin
    count_d = count_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    we      = 1'b0;
    waddr   = AW'(count_q);
    if (ena) begin
      if (clr_err) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      unique case (op)
        OP_PUSH: begin
          if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            we      = 1'b1;
            count_d = count_q + CNT_W'(1);
          end
        end
        OP_POP: begin
          if (is_empty) begin
            unf_d = 1'b1;
          end else begin
            dout_d  = rdata;
            dv_d    = 1'b1;
            count_d = count_q - CNT_W'(1);
          end
        end
        OP_REPLACE: begin
          we = 1'b1;
          if (is_empty) begin
            count_d = CNT_W'(1);
          end else begin
            waddr  = raddr;
            dout_d = rdata;
            dv_d   = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count      = count_q;
  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;
  assign empty      = is_empty;
  assign full       = is_full;
  assign top        = is_empty ? '0 : rdata;

endmodule

// File: tb/tb_stack_lifo_core.sv
// Directed bench for stack_lifo_core at DEPTH=4, DATA_W=8.
// Expected values are hand-computed per vector.
module tb_stack_lifo_core;

  localparam int DW = 8;
  localparam int DP = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          push;
  logic          pop;
  logic [DW-1:0] din;
  logic          clr_err;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic [DW-1:0] top;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  int n_vec = 0;
  int n_err = 0;

  stack_lifo_core #(
    .DATA_W (DW),
    .DEPTH  (DP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .push       (push),
    .pop        (pop),
    .din        (din),
    .clr_err    (clr_err),
    .dout       (dout),
    .dout_valid (dout_valid),
    .top        (top),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic          p,
    input logic          q,
    input logic [DW-1:0] d,
    input logic          c
  );
    push    = p;
    pop     = q;
    din     = d;
    clr_err = c;
  endtask

  logic [DW-1:0] pop_exp [4];

  initial begin
    pop_exp[0] = 8'h44;
    pop_exp[1] = 8'h33;
    pop_exp[2] = 8'h22;
    pop_exp[3] = 8'h11;

    rst_n = 1'b0;
    ena   = 1'b1;
    drive(1'b1, 1'b0, 8'hAA, 1'b0);
    tick();
    tick();
    chk("rst_cnt_held", 32'(count), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("rst_cnt", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_dv", 32'(dout_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
    chk("rst_top", 32'(top), 32'h00);

    drive(1'b1, 1'b0, 8'h11, 1'b0);
    tick();
    chk("push1_top", 32'(top), 32'h11);
    drive(1'b1, 1'b0, 8'h22, 1'b0);
    tick();
    drive(1'b1, 1'b0, 8'h33, 1'b0);
    tick();
    drive(1'b1, 1'b0, 8'h44, 1'b0);
    tick();
    chk("fill_cnt", 32'(count), 32'd4);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_top", 32'(top), 32'h44);
    chk("fill_dv", 32'(dout_valid), 32'd0);

    drive(1'b1, 1'b0, 8'h55, 1'b0);
    tick();
    chk("ovf_cnt", 32'(count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_top", 32'(top), 32'h44);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    chk("ovf_clr", 32'(overflow), 32'd0);

    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 8'h00, 1'b0);
      tick();
      chk($sformatf("pop%0d_dout", i), 32'(dout), 32'(pop_exp[i]));
      chk($sformatf("pop%0d_dv", i), 32'(dout_valid), 32'd1);
      chk($sformatf("pop%0d_cnt", i), 32'(count), 32'(3 - i));
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      chk($sformatf("pop%0d_dv_drop", i), 32'(dout_valid), 32'd0);
      chk($sformatf("pop%0d_hold", i), 32'(dout), 32'(pop_exp[i]));
    end
    chk("drain_empty", 32'(empty), 32'd1);

    drive(1'b0, 1'b1, 8'h00, 1'b0);
    tick();
    chk("unf_flag", 32'(underflow), 32'd1);
    chk("unf_dout", 32'(dout), 32'h11);
    chk("unf_dv", 32'(dout_valid), 32'd0);
    chk("unf_cnt", 32'(count), 32'd0);
    drive(1'b0, 1'b1, 8'h00, 1'b1);
    tick();
    chk("unf_setwins", 32'(underflow), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    chk("unf_clr", 32'(underflow), 32'd0);

    drive(1'b1, 1'b0, 8'hA1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 8'hB2, 1'b0);
    tick();
    drive(1'b1, 1'b1, 8'hC3, 1'b0);
    tick();
    chk("rep_dout", 32'(dout), 32'hB2);
    chk("rep_dv", 32'(dout_valid), 32'd1);
    chk("rep_cnt", 32'(count), 32'd2);
    chk("rep_top", 32'(top), 32'hC3);
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    tick();
    chk("rep_pop1", 32'(dout), 32'hC3);
    tick();
    chk("rep_pop2", 32'(dout), 32'hA1);
    chk("rep_empty", 32'(empty), 32'd1);

    drive(1'b1, 1'b1, 8'h7E, 1'b0);
    tick();
    chk("repe_cnt", 32'(count), 32'd1);
    chk("repe_top", 32'(top), 32'h7E);
    chk("repe_dv", 32'(dout_valid), 32'd0);
    chk("repe_unf", 32'(underflow), 32'd0);

    ena = 1'b0;
    drive(1'b1, 1'b0, 8'h99, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("dis%0d_cnt", i), 32'(count), 32'd1);
    end
    chk("dis_ovf", 32'(overflow), 32'd0);
    chk("dis_unf", 32'(underflow), 32'd0);
    chk("dis_top", 32'(top), 32'h7E);
    ena = 1'b1;
    tick();
    chk("ena_cnt", 32'(count), 32'd2);
    chk("ena_top", 32'(top), 32'h99);

    drive(1'b1, 1'b0, 8'hAA, 1'b0);
    tick();
    drive(1'b1, 1'b0, 8'hBB, 1'b0);
    tick();
    drive(1'b1, 1'b1, 8'hCC, 1'b0);
    tick();
    chk("repf_dout", 32'(dout), 32'hBB);
    chk("repf_cnt", 32'(count), 32'd4);
    chk("repf_top", 32'(top), 32'hCC);
    chk("repf_ovf", 32'(overflow), 32'd0);
    ena = 1'b0;
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    tick();
    chk("dis_dv_drop", 32'(dout_valid), 32'd0);
    chk("dis_pop_cnt", 32'(count), 32'd4);

    ena = 1'b1;
    drive(1'b1, 1'b0, 8'h12, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", 32'(count), 32'd0);
    chk("arst_dout", 32'(dout), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stack_lifo_core.md
Name: stack_lifo_core

Overview:
- Parametrised LIFO stack core, the successor to the fixed 8-bit / 256-entry tile stack.
- Adds configurable width and depth, full/empty/count status, sticky overflow/underflow errors, a combined push+pop "replace top" operation and a registered pop-data handshake.
- Intended to sit behind the tile top-level pin wrapper, which maps ui_in/uio_in/uo_out onto these ports.

Parameters:
- DATA_W, 8, data word width in bits.
- DEPTH, 16, number of stack entries; must be ≥2; power of two not required.
- CNT_W, $clog2(DEPTH+1), width of the count output (derived, not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  block enable; when low, push/pop/clr_err are ignored and state holds.
- push  in  1  push request, sampled on rising clk.
- pop  in  1  pop request, sampled on rising clk.
- din  in  DATA_W  data to push.
- clr_err  in  1  clears the sticky error flags.
- dout  out  DATA_W  registered data of the last successful pop or replace.
- dout_valid  out  1  one-cycle pulse, high the cycle after a successful pop or replace.
- top  out  DATA_W  combinational peek of the current top entry; 0 when empty.
- count  out  CNT_W  number of valid entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky: a push was rejected.
- underflow  out  1  sticky: a pop was rejected.

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream): count=0, dout=0, dout_valid=0, overflow=0, underflow=0, empty=1, full=0. Memory contents are not reset.
- Reset mid-operation discards the in-flight operation; the stack is logically empty afterwards.
- Storage: mem[0..DEPTH-1]; sp = count; the top entry is mem[count-1].
- All operations apply only when ena=1, at the rising edge of clk.
- push only, not full: mem[count] <= din; count +1. No dout change, dout_valid=0.
- push only, full: ignored; overflow <= 1; count unchanged.
- pop only, not empty: dout <= mem[count-1]; count -1; dout_valid high for exactly the next cycle.
- pop only, empty: ignored; underflow <= 1; dout unchanged; dout_valid stays 0.
- push+pop, not empty (replace): dout <= old mem[count-1]; mem[count-1] <= din; count unchanged; dout_valid pulses. This is legal when full.
- push+pop, empty: behaves as push only (count becomes 1, dout_valid=0). Underflow is not flagged.
- clr_err=1: overflow and underflow clear on that edge. If a new error occurs in the same cycle, set wins.
- dout_valid returns to 0 on any cycle with no successful pop or replace.
- top is derived from the current count (1-cycle read after write): after a push at edge N, top equals din from edge N onward.
- Counter arithmetic is unsigned CNT_W bits; it never wraps, because the full/empty guards prevent it.
- No operation when ena=0, including error setting; outputs hold, except dout_valid, which drops to 0.

Decomposition:
- Shared package stack_pkg: op enumeration OP_IDLE/OP_PUSH/OP_POP/OP_REPLACE decoded from {push,pop}, and a cnt_width(depth) function.
- One sub-module, stack_mem: DATA_W×DEPTH, 1 synchronous write port and 1 asynchronous read port, no reset.
- Core control (op decode, count, flags, dout register) stays in stack_lifo_core.

Test Plan (DEPTH=4, DATA_W=8):
- Reset with rst_n=0 held mid-push, then release → count=0, empty=1, full=0, dout=0x00, overflow=0, underflow=0.
- Push 0x11, 0x22, 0x33, 0x44 → count=4, full=1, top=0x44. Then pop ×4 → dout 0x44, 0x33, 0x22, 0x11, each with a single-cycle dout_valid pulse; final empty=1.
- On a full stack, push 0x55 → count stays 4, overflow=1, top=0x44. Then clr_err → overflow=0.
- On an empty stack, pop → underflow=1, dout unchanged, dout_valid=0. Pop+clr_err in the same cycle → underflow=1 (set wins).
- Stack holds 0xA1,0xB2; push+pop with din=0xC3 → dout=0xB2, dout_valid=1, count=2, top=0xC3. On an empty stack, push+pop with din=0x7E → count=1, top=0x7E, dout_valid=0.
- ena=0 with push=1 din=0x99 for 3 cycles → count unchanged, no flags set. Raise ena → next push accepted, count increments by exactly 1.
